// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared state encoding, defaults and sizing helper for the PE column feeder
//   STATE_W          width of the one-hot state vector (matches the PE state encoding width)
//   state_t          one-hot feeder states IDLE, LOAD_C, LOAD_A, LOAD_B, WAIT_RES
//   f_log2(n)        bits needed to hold 0..n-1 (never less than 1)
package pe_array_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ARRAY_SIZE = 16;
    localparam int STATE_W        = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 8'h01,
        S_LOAD_C   = 8'h02,
        S_LOAD_A   = 8'h04,
        S_LOAD_B   = 8'h08,
        S_WAIT_RES = 8'h10
    } state_t;

    function automatic int f_log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// pe_result_fifo: synchronous first-word-fall-through FIFO for column results
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_data   write strobe and word (ignored when full unless popping)
//   i_pop            read strobe (ignored when empty)
//   o_data           head word, valid whenever o_empty is low
//   o_empty, o_full  occupancy flags
//   o_count          number of stored words
module pe_result_fifo
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_ARRAY_SIZE
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [f_log2(DEPTH+1)-1:0]    o_count
);

    localparam int AW = f_log2(DEPTH);
    localparam int CW = f_log2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    // When full, a simultaneous pop frees the slot the write pointer aims at.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? ((r_wr == AW'(DEPTH-1)) ? '0 : r_wr + AW'(1)) : r_wr;
            r_rd    <= w_pop  ? ((r_rd == AW'(DEPTH-1)) ? '0 : r_rd + AW'(1)) : r_rd;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/pe_column_feeder.sv
// pe_column_feeder: streams one batch (C, A, B words) into a PE column and collects its results
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               begin batch (only in IDLE with result FIFO empty)
//   o_busy, o_done        not-IDLE flag, one-cycle batch end pulse
//   o_timeout             sticky result-wait expiry flag, cleared by an accepted start
//   i_s_data/valid, o_s_ready           host input stream
//   o_pe_ap_start, o_pe_ap_ctrl, o_pe_col_data   registered column bus drivers
//   i_pe_res_valid, i_pe_res_data      column result broadcast
//   o_m_data/valid, i_m_ready           host result stream
//   o_state               one-hot FSM state
module pe_column_feeder
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
    parameter int MATRIX_DEPTH = 8000,
    parameter int TIMEOUT      = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic                  o_pe_ap_start,
    output logic                  o_pe_ap_ctrl,
    output logic [DATA_WIDTH-1:0] o_pe_col_data,
    input  logic                  i_pe_res_valid,
    input  logic [DATA_WIDTH-1:0] i_pe_res_data,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [STATE_W-1:0]    o_state
);

    localparam int BEAT_MAX = (MATRIX_DEPTH > ARRAY_SIZE) ? MATRIX_DEPTH : ARRAY_SIZE;
    localparam int BW       = f_log2(BEAT_MAX);
    localparam int RW       = f_log2(ARRAY_SIZE);
    localparam int TW       = f_log2(TIMEOUT + 1);
    localparam int CW       = f_log2(ARRAY_SIZE + 1);

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_beat;
    logic [RW-1:0]         r_res;
    logic [TW-1:0]         r_cyc;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_ap_start;
    logic                  r_ap_ctrl;
    logic [DATA_WIDTH-1:0] r_col_data;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_push;
    logic                  w_res_last;
    logic                  w_expire;
    logic                  w_start_ok;
    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_count;

    assign o_busy        = r_state != S_IDLE;
    assign o_s_ready     = (r_state == S_LOAD_C) | (r_state == S_LOAD_A) | (r_state == S_LOAD_B);
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_pe_ap_start = r_ap_start;
    assign o_pe_ap_ctrl  = r_ap_ctrl;
    assign o_pe_col_data = r_col_data;
    assign o_m_valid     = ~w_empty;
    assign o_state       = r_state;

    assign w_accept    = i_s_valid & o_s_ready;
    assign w_last_beat = r_beat == ((r_state == S_LOAD_C) ? BW'(ARRAY_SIZE-1) : BW'(MATRIX_DEPTH-1));
    assign w_push      = (r_state == S_WAIT_RES) & i_pe_res_valid & ~w_full;
    assign w_res_last  = w_push & (r_res == RW'(ARRAY_SIZE-1));
    assign w_expire    = (r_state == S_WAIT_RES) & (r_cyc == TW'(TIMEOUT-1));
    assign w_start_ok  = (r_state == S_IDLE) & i_start & (w_count == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = w_start_ok ? S_LOAD_C : S_IDLE;
            S_LOAD_C:   w_next = (w_accept & w_last_beat) ? S_LOAD_A : S_LOAD_C;
            S_LOAD_A:   w_next = (w_accept & w_last_beat) ? S_LOAD_B : S_LOAD_A;
            S_LOAD_B:   w_next = (w_accept & w_last_beat) ? S_WAIT_RES : S_LOAD_B;
            S_WAIT_RES: w_next = (w_res_last | w_expire) ? S_IDLE : S_WAIT_RES;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_res      <= '0;
            r_cyc      <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ap_start <= 1'b0;
            r_ap_ctrl  <= 1'b0;
            r_col_data <= '0;
        end else begin
            r_state    <= w_next;
            r_beat     <= (w_next != r_state) ? '0 : w_accept ? r_beat + BW'(1) : r_beat;
            r_res      <= w_start_ok ? '0 : w_push ? r_res + RW'(1) : r_res;
            r_cyc      <= (r_state == S_WAIT_RES) ? r_cyc + TW'(1) : '0;
            r_done     <= w_res_last | w_expire;
            // A final result arriving on the expiry cycle completes the batch normally.
            r_timeout  <= w_start_ok ? 1'b0 : (w_expire & ~w_res_last) ? 1'b1 : r_timeout;
            r_ap_start <= w_accept & (r_state == S_LOAD_C) & w_last_beat;
            r_ap_ctrl  <= w_accept;
            r_col_data <= w_accept ? i_s_data : r_col_data;
        end
    end

    pe_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (ARRAY_SIZE)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_pe_res_data),
        .i_pop   (i_m_ready),
        .o_data  (o_m_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

endmodule
